button_debouncer: RTL

//  Multi-channel push-button debouncer and edge detector for the board inputs.

---
 rtl/button_debouncer.sv | 83 ++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: polarity fix, 2-flop synchroniser,
// tick-sampled stability counter per channel, and registered rise/fall pulses.
module button_debouncer #(
  parameter int P_WIDTH      = 4,
  parameter int P_STABLE     = 4,
  parameter int P_ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iTick,
  input  logic [P_WIDTH-1:0] iBtn,
  output logic [P_WIDTH-1:0] oLevel,
  output logic [P_WIDTH-1:0] oRise,
  output logic [P_WIDTH-1:0] oFall
);

  localparam int CW = $clog2(P_STABLE + 1);
  // Count value at which one more differing sample commits the new level.
  localparam logic [CW-1:0] LAST_CNT = CW'(P_STABLE - 1);

  logic [P_WIDTH-1:0] btn_pol_s;
  logic [P_WIDTH-1:0] sync1_q, sync1_d;
  logic [P_WIDTH-1:0] sync2_q, sync2_d;
  logic [CW-1:0]      cnt_q [P_WIDTH];
  logic [CW-1:0]      cnt_d [P_WIDTH];
  logic [P_WIDTH-1:0] level_q, level_d;
  logic [P_WIDTH-1:0] rise_q, rise_d;
  logic [P_WIDTH-1:0] fall_q, fall_d;

  assign btn_pol_s = (P_ACTIVE_LOW != 0) ? ~iBtn : iBtn;

  // Next-state logic: synchroniser shift, per-channel stability count and commit.
  always_comb begin
    sync1_d = btn_pol_s;
    sync2_d = sync1_q;
    level_d = level_q;
    for (int b = 0; b < P_WIDTH; b++) begin
      cnt_d[b] = cnt_q[b];
      if (iTick) begin
        if (sync2_q[b] == level_q[b]) begin
          cnt_d[b] = '0;
        end else if (cnt_q[b] == LAST_CNT) begin
          level_d[b] = sync2_q[b];
          cnt_d[b]   = '0;
        end else begin
          cnt_d[b] = cnt_q[b] + CW'(1);
        end
      end else begin
        cnt_d[b] = cnt_q[b];
      end
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int b = 0; b < P_WIDTH; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int b = 0; b < P_WIDTH; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  assign oLevel = level_q;
  assign oRise  = rise_q;
  assign oFall  = fall_q;

endmodule
